// File: rtl/vert_ucode_quicksort_fetch.sv
// Microcode fetch unit for the vertical quicksort sequencer: issues ROM reads
// and queues returned instructions with their PCs for the decode stage.
module vert_ucode_quicksort_fetch #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned INST_W    = 16,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_vld,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              busy
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0]   OCC_FULL = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              infl_q, infl_d;
  logic [PC_W-1:0]   infl_pc_q, infl_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INST_W-1:0] buf_inst_q [BUF_DEPTH];
  logic [INST_W-1:0] buf_inst_d [BUF_DEPTH];
  logic [PC_W-1:0]   buf_pc_q   [BUF_DEPTH];
  logic [PC_W-1:0]   buf_pc_d   [BUF_DEPTH];

  logic            run;
  logic            xfer;
  logic            issue;
  logic [CNT_W:0]  occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and read-issue decisions; the in-flight read counts against
  // buffer space so a response always has a slot waiting for it.
  always_comb begin
    run     = (state_q == ST_RUN);
    occ     = {1'b0, cnt_q} + (CNT_W + 1)'(infl_q);
    out_vld = run && (cnt_q != '0) && !redirect_vld && !halt;
    xfer    = out_vld && out_rdy;
    issue   = run && !halt && !redirect_vld &&
              ((occ < OCC_FULL) || ((occ == OCC_FULL) && xfer));
    imem_en   = issue;
    imem_addr = issue ? pc_q : '0;
    out_inst  = (cnt_q != '0) ? buf_inst_q[head_q] : '0;
    out_pc    = (cnt_q != '0) ? buf_pc_q[head_q] : '0;
    busy      = run;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    infl_d     = infl_q;
    infl_pc_d  = infl_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          infl_d  = 1'b0;
          head_d  = '0;
          tail_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (halt || redirect_vld) begin
          // Flush: queued entries and any returning response are dropped.
          if (halt) begin
            state_d = ST_IDLE;
          end else begin
            pc_d = redirect_pc;
          end
          infl_d = 1'b0;
          head_d = '0;
          tail_d = '0;
          cnt_d  = '0;
        end else begin
          infl_d = issue;
          if (issue) begin
            pc_d      = pc_q + PC_W'(1);
            infl_pc_d = pc_q;
          end
          if (infl_q) begin
            buf_inst_d[tail_q] = imem_rdata;
            buf_pc_d[tail_q]   = infl_pc_q;
            tail_d             = ptr_inc(tail_q);
          end
          if (xfer) begin
            head_d = ptr_inc(head_q);
          end
          cnt_d = cnt_q + CNT_W'(infl_q) - CNT_W'(xfer);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule
